// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the round-robin memory arbiter.
package mem_arb_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_ADDR_W  = 2;
  localparam int DEF_DATA_W  = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    CLEAR  = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request searching upward from ptr+1.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  win_onehot,
  output logic [IW-1:0] win_idx,
  output logic          win_valid
);

  logic [IW:0]   sum_s;
  logic [IW-1:0] cand_s;
  logic          hit_s;

  // Walk the N candidates in priority order, keeping only the first hit.
  always_comb begin
    win_onehot = '0;
    win_idx    = '0;
    win_valid  = 1'b0;
    sum_s      = '0;
    cand_s     = '0;
    hit_s      = 1'b0;
    for (int off = 1; off <= N; off++) begin
      sum_s      = {1'b0, ptr} + (IW+1)'(off);
      sum_s      = (sum_s >= (IW+1)'(N)) ? (sum_s - (IW+1)'(N)) : sum_s;
      cand_s     = sum_s[IW-1:0];
      hit_s      = !win_valid && req[cand_s];
      win_onehot = win_onehot | ({{(N-1){1'b0}}, hit_s} << cand_s);
      win_idx    = hit_s ? cand_s : win_idx;
      win_valid  = win_valid | hit_s;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port byte memory between NUM_REQ requesters (one access per
// grant, registered read return) and runs a zero-fill sequence on clr_req.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  input  logic                      clr_req,
  output logic                      busy,
  output logic                      clr_done,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic                      mem_we,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int IW    = $clog2(NUM_REQ);

  state_t              state_q, state_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic [IW-1:0]       acc_idx_q, acc_idx_d;
  logic                acc_rd_q, acc_rd_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [NUM_REQ-1:0]  rvalid_q, rvalid_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                busy_q, busy_d;
  logic                clr_done_q, clr_done_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                mem_we_q, mem_we_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

  logic [NUM_REQ-1:0]  win_onehot_s;
  logic [IW-1:0]       win_idx_s;
  logic                win_valid_s;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req        (req),
    .ptr        (ptr_q),
    .win_onehot (win_onehot_s),
    .win_idx    (win_idx_s),
    .win_valid  (win_valid_s)
  );

  // Next-state and next-output logic; the memory port is driven straight from
  // registers that are loaded on entry to ACCESS or CLEAR.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    acc_idx_d   = acc_idx_q;
    acc_rd_d    = acc_rd_q;
    clr_cnt_d   = clr_cnt_q;
    gnt_d       = '0;
    rvalid_d    = '0;
    rdata_d     = rdata_q;
    busy_d      = busy_q;
    clr_done_d  = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d     = CLEAR;
          busy_d      = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
          clr_cnt_d   = '0;
        end else if (win_valid_s) begin
          state_d     = ACCESS;
          busy_d      = 1'b1;
          gnt_d       = win_onehot_s;
          acc_idx_d   = win_idx_s;
          acc_rd_d    = !req_we[win_idx_s];
          mem_we_d    = req_we[win_idx_s];
          mem_addr_d  = req_addr[int'(win_idx_s)*ADDR_W +: ADDR_W];
          mem_wdata_d = req_wdata[int'(win_idx_s)*DATA_W +: DATA_W];
        end else begin
          busy_d = 1'b0;
        end
      end
      ACCESS: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        ptr_d   = acc_idx_q;
        if (acc_rd_q) begin
          rdata_d             = mem_rdata;
          rvalid_d[acc_idx_q] = 1'b1;
        end else begin
          rdata_d = rdata_q;
        end
      end
      CLEAR: begin
        if (clr_cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d    = IDLE;
          busy_d     = 1'b0;
          clr_done_d = 1'b1;
          clr_cnt_d  = '0;
        end else begin
          mem_we_d   = 1'b1;
          clr_cnt_d  = clr_cnt_q + ADDR_W'(1);
          mem_addr_d = clr_cnt_q + ADDR_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; pointer resets so requester 0 wins first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      ptr_q       <= IW'(NUM_REQ - 1);
      acc_idx_q   <= '0;
      acc_rd_q    <= 1'b0;
      clr_cnt_q   <= '0;
      gnt_q       <= '0;
      rvalid_q    <= '0;
      rdata_q     <= '0;
      busy_q      <= 1'b0;
      clr_done_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      acc_idx_q   <= acc_idx_d;
      acc_rd_q    <= acc_rd_d;
      clr_cnt_q   <= clr_cnt_d;
      gnt_q       <= gnt_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      busy_q      <= busy_d;
      clr_done_q  <= clr_done_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign gnt       = gnt_q;
  assign rvalid    = rvalid_q;
  assign rdata     = rdata_q;
  assign busy      = busy_q;
  assign clr_done  = clr_done_q;
  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a transaction-level model predicts each
// grant, clear write, clr_done and read return; a negedge monitor checks them.
module tb_mem_arbiter;

  localparam int N     = 4;
  localparam int AW    = 2;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    req, req_we;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    gnt, rvalid;
  logic [DW-1:0]   rdata;
  logic            clr_req, busy, clr_done;
  logic [AW-1:0]   mem_addr;
  logic            mem_we;
  logic [DW-1:0]   mem_wdata, mem_rdata;

  logic [DW-1:0]   tb_mem [DEPTH];
  logic            ovr_en;
  logic [DW-1:0]   ovr_val;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    int            kind;   // 0 access, 1 clear write, 2 clr_done
    int            cyc;
    int            idx;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ev_t;

  ev_t ev_q[$];
  ev_t rd_q[$];

  always #5 clk = ~clk;

  mem_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .clr_req   (clr_req),
    .busy      (busy),
    .clr_done  (clr_done),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // The memory device itself: combinational read, write on the clock edge.
  assign mem_rdata = ovr_en ? ovr_val : tb_mem[mem_addr];
  always @(posedge clk) if (mem_we) tb_mem[mem_addr] <= mem_wdata;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name, input longint act);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got %0h expected nothing at %0t", name, act, $time);
  endtask

  // Reference model: decides what the arbiter must do from the spec rules alone.
  int            m_cyc       = 0;
  int            m_idle_from = 0;
  int            m_last      = N - 1;
  int            m_clr_start = 0;
  bit            m_clr_act   = 1'b0;
  logic [DW-1:0] m_mem [DEPTH];

  initial begin : model
    ev_t e;
    int  prev;
    int  w;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        ev_q.delete();
        rd_q.delete();
        m_last      = N - 1;
        m_idle_from = m_cyc;
        m_clr_act   = 1'b0;
      end else begin
        m_cyc++;
        prev = m_cyc - 1;
        if (m_clr_act) begin
          m_mem[prev - m_clr_start] = '0;
          if (prev - m_clr_start == DEPTH - 1) m_clr_act = 1'b0;
        end
        if (prev >= m_idle_from) begin
          if (clr_req) begin
            for (int k = 0; k < DEPTH; k++) begin
              e = '{kind: 1, cyc: m_cyc + k, idx: 0, we: 1'b1, addr: AW'(k), data: '0};
              ev_q.push_back(e);
            end
            e = '{kind: 2, cyc: m_cyc + DEPTH, idx: 0, we: 1'b0, addr: '0, data: '0};
            ev_q.push_back(e);
            m_clr_act   = 1'b1;
            m_clr_start = m_cyc;
            m_idle_from = m_cyc + DEPTH;
          end else if (req != '0) begin
            w = -1;
            for (int k = 1; k <= N; k++)
              if (w < 0 && req[(m_last + k) % N]) w = (m_last + k) % N;
            e.kind = 0;
            e.cyc  = m_cyc;
            e.idx  = w;
            e.we   = req_we[w];
            e.addr = req_addr[w*AW +: AW];
            e.data = req_wdata[w*DW +: DW];
            ev_q.push_back(e);
            if (e.we) begin
              m_mem[e.addr] = e.data;
            end else begin
              e.cyc  = m_cyc + 1;
              e.data = ovr_en ? ovr_val : m_mem[e.addr];
              rd_q.push_back(e);
            end
            m_last      = w;
            m_idle_from = m_cyc + 1;
          end
        end
      end
    end
  end

  // Monitor: every observed DUT event must match the head of the scoreboard.
  initial begin : monitor
    ev_t e;
    int  obs;
    forever begin
      @(negedge clk);
      if (rst) begin
        check("busy", busy, (gnt != '0) || mem_we);
        check("gnt_onehot", $countones(gnt) <= 1, 1);
        check("rvalid_onehot", $countones(rvalid) <= 1, 1);
        while (ev_q.size() > 0 && ev_q[0].cyc < m_cyc) begin
          flag("missed_event", ev_q[0].kind);
          void'(ev_q.pop_front());
        end
        while (rd_q.size() > 0 && rd_q[0].cyc < m_cyc) begin
          flag("missed_rvalid", rd_q[0].idx);
          void'(rd_q.pop_front());
        end
        if (gnt != '0 || mem_we || clr_done) begin
          obs = (gnt != '0) ? 0 : (mem_we ? 1 : 2);
          if (ev_q.size() == 0) begin
            flag("unexpected_event", obs);
          end else begin
            e = ev_q.pop_front();
            check("event_kind", obs, e.kind);
            check("event_cycle", m_cyc, e.cyc);
            check("clr_done", clr_done, e.kind == 2);
            if (e.kind == 0) begin
              check("gnt", gnt, 1 << e.idx);
              check("acc_we", mem_we, e.we);
              check("acc_addr", mem_addr, e.addr);
              if (e.we) check("acc_wdata", mem_wdata, e.data);
            end else if (e.kind == 1) begin
              check("clr_addr", mem_addr, e.addr);
              check("clr_wdata", mem_wdata, 0);
            end
          end
        end
        if (rvalid != '0) begin
          if (rd_q.size() == 0) begin
            flag("unexpected_rvalid", rvalid);
          end else begin
            e = rd_q.pop_front();
            check("rvalid", rvalid, 1 << e.idx);
            check("rvalid_cycle", m_cyc, e.cyc);
            check("rdata", rdata, e.data);
          end
        end
      end
    end
  end

  // Requester behaviour: drop req in the cycle after its gnt.
  task automatic step();
    @(negedge clk);
    for (int i = 0; i < N; i++) if (gnt[i]) req[i] = 1'b0;
  endtask

  task automatic issue(input int i, input bit we, input int a, input int d);
    req[i]                 = 1'b1;
    req_we[i]              = we;
    req_addr[i*AW +: AW]   = AW'(a);
    req_wdata[i*DW +: DW]  = DW'(d);
  endtask

  task automatic wait_idle(input int max_cyc);
    int n;
    n = 0;
    step();
    while ((req != '0 || ev_q.size() != 0 || rd_q.size() != 0) && n < max_cyc) begin
      step();
      n++;
    end
    if (n >= max_cyc) flag("timeout_wait_idle", n);
    step();
  endtask

  task automatic do_reset();
    rst     = 1'b0;
    req     = '0;
    clr_req = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  initial begin : stim
    int n;
    req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    clr_req = 1'b0; ovr_en = 1'b0; ovr_val = '0;
    step();
    step();
    check("rst_gnt", gnt, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_busy", busy, 0);
    check("rst_clr_done", clr_done, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_rdata", rdata, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    rst = 1'b1;

    // Zero both memories so later reads have known contents.
    step();
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    wait_idle(20);

    issue(2, 1'b1, 1, 8'hA5);
    wait_idle(10);
    issue(0, 1'b0, 1, 0);
    wait_idle(10);

    do_reset();
    for (int i = 0; i < N; i++) issue(i, 1'b1, i, 8'h10 + i);
    wait_idle(40);

    clr_req = 1'b1;
    issue(1, 1'b0, 2, 0);
    step();
    clr_req = 1'b0;
    wait_idle(20);
    issue(0, 1'b0, 1, 0);
    wait_idle(10);

    // Asynchronous reset in the middle of a clear.
    issue(2, 1'b1, 2, 8'h77);
    wait_idle(10);
    issue(3, 1'b1, 0, 8'h99);
    wait_idle(10);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    step();
    #2 rst = 1'b0;
    #1;
    check("midclr_busy", busy, 0);
    check("midclr_mem_we", mem_we, 0);
    check("midclr_mem_addr", mem_addr, 0);
    check("midclr_clr_done", clr_done, 0);
    check("midclr_gnt", gnt, 0);
    req = '0;
    step();
    step();
    rst = 1'b1;
    issue(1, 1'b0, 2, 0);
    issue(0, 1'b0, 0, 0);
    wait_idle(20);

    ovr_val = 8'h3C;
    ovr_en  = 1'b1;
    issue(3, 1'b0, 3, 0);
    n = 0;
    while (rvalid == '0 && n < 10) begin
      step();
      n++;
    end
    if (n >= 10) flag("timeout_rvalid3", n);
    ovr_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("rdata_hold", rdata, 8'h3C);
    end

    for (int it = 0; it < 400; it++) begin
      step();
      clr_req = ($urandom_range(0, 39) == 0);
      for (int i = 0; i < N; i++)
        if (!req[i] && !gnt[i] && $urandom_range(0, 3) == 0)
          issue(i, 1'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH-1)),
                int'($urandom_range(0, 255)));
    end
    clr_req = 1'b0;
    wait_idle(100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one single-port byte memory between NUM_REQ requesters.
- Each granted request becomes exactly one memory cycle: a write, or a read with registered data return.
- Also runs a clear sequence that zero-fills every address on request.
- Sits between client blocks and the memory's addr/we/data_input/data_output port.

Parameters:
NUM_REQ, 4, number of requesters (≥2)
ADDR_W, 2, memory address width
DATA_W, 8, memory data width
DEPTH (localparam), 1<<ADDR_W, addresses walked by clear

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
req  input  NUM_REQ  per-requester access request, held until gnt
req_we  input  NUM_REQ  1=write, 0=read, per requester
req_addr  input  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
req_wdata  input  NUM_REQ*DATA_W  packed write data, same packing
gnt  output  NUM_REQ  one-hot, one-cycle pulse during the granted access
rvalid  output  NUM_REQ  one-hot, one-cycle pulse: rdata valid for requester i
rdata  output  DATA_W  registered read data, shared by all requesters
clr_req  input  1  start a zero-fill of all DEPTH addresses
busy  output  1  high while in ACCESS or CLEAR
clr_done  output  1  one-cycle pulse after the last clear write
mem_addr  output  ADDR_W  memory address
mem_we  output  1  memory write enable
mem_wdata  output  DATA_W  memory write data
mem_rdata  input  DATA_W  memory read data, combinational from mem_addr while mem_we=0

Behaviour:
- Reset (rst=0, asynchronous):
  - State IDLE; gnt, rvalid, busy, clr_done, mem_we all 0.
  - rdata, mem_addr, mem_wdata are 0.
  - Round-robin pointer set so requester 0 has highest priority.
- FSM states: IDLE, ACCESS, CLEAR.
- IDLE:
  - mem_we=0.
  - If clr_req=1, go to CLEAR. Clear has priority over all requesters.
  - Else if any req bit is set, pick the winner by round-robin: the first set bit searching upward from (last winner + 1) mod NUM_REQ.
  - Register the winner index, req_we, req_addr and req_wdata into the access registers. gnt[winner] is set and the state goes to ACCESS.
  - Else stay in IDLE.
- ACCESS (exactly 1 cycle):
  - mem_addr, mem_we and mem_wdata are driven from the access registers; gnt[winner]=1; busy=1.
  - Write: the memory commits on the closing edge.
  - Read: rdata <= mem_rdata on the closing edge, and rvalid[winner]=1 for the following cycle.
  - Pointer updates to the winner. Always returns to IDLE.
- Latency and throughput:
  - Request sampled at edge E. gnt is high during cycle E+1. Read data and rvalid are valid in cycle E+2.
  - Maximum throughput is one access per 2 cycles.
- Requester handshake:
  - A requester holds req and its address/data stable until it sees gnt, and drops req in the cycle after gnt.
  - A req still high in the gnt cycle is treated as a new request at the next IDLE. It gets no priority bump; the pointer has moved past it.
- CLEAR:
  - mem_we=1, mem_wdata=0, and mem_addr counts 0..DEPTH-1, one address per cycle. busy=1.
  - After writing address DEPTH-1: go to IDLE, clr_done pulses for 1 cycle, and the counter resets to 0.
  - clr_req asserted during CLEAR is ignored; there is no restart.
  - Requests wait in CLEAR and are served in round-robin order afterwards.
- Simultaneous events:
  - clr_req and req in the same IDLE cycle: CLEAR wins, and req waits with no gnt.
  - Only one gnt and at most one rvalid bit are ever high at a time.
- Reset mid-operation:
  - Reset during ACCESS aborts with no rvalid.
  - Reset during CLEAR aborts with no clr_done; the memory is left partially cleared.
- req bits for the granted requester are don't-care during ACCESS.

Decomposition:
- Package mem_arb_pkg holds:
  - typedef enum state_t {IDLE, ACCESS, CLEAR};
  - default width constants ADDR_W=2, DATA_W=8, NUM_REQ=4.
- Sub-module rr_arbiter (parameter N):
  - inputs: req[N], ptr index.
  - outputs: one-hot winner and winner index, both combinational.
- mem_arbiter instantiates rr_arbiter and owns the FSM, the pointer register, the access registers and the clear counter.

Test Plan:
1. Reset, then req[2]=1 write, addr=1, wdata=8'hA5 → gnt[2] one cycle later, mem_we=1, mem_addr=1, mem_wdata=A5 for exactly 1 cycle; busy=1 in that cycle only.
2. After test 1, req[0] read of addr 1 → gnt[0], then next cycle rvalid[0]=1 and rdata=8'hA5.
3. req=4'b1111 held continuously, each requester dropping req after its gnt → grants in order 0,1,2,3, spaced 2 cycles apart; never two gnt bits high.
4. clr_req=1 together with req[1] → CLEAR; mem_we=1 and mem_addr=0,1,2,3 with wdata=0 over 4 cycles; then clr_done pulse; then gnt[1]; reading addr 1 afterwards returns 8'h00.
5. rst=0 asserted asynchronously mid-CLEAR (after addr 1) → all outputs 0 immediately, no clr_done; after release, IDLE with requester 0 highest priority.
6. req[3] read with mem_rdata driven to 8'h3C → rvalid[3]=1, rdata=3C, rvalid[0..2]=0; rdata holds 3C until the next read.
